spm_seq: RTL and testbench



---
 rtl/spm_seq.sv | 130 +++++++++++++
 tb/tb_spm_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spm_seq.sv
// Sequencer for the serial-parallel multiplier core: latches signed operands, streams the
// sign-extended multiplier LSB-first and deserializes the product stream into a parallel result.
module spm_seq #(
    parameter int unsigned SIZE = 32,
    parameter int unsigned LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   mc,
    input  logic [SIZE-1:0]   mp,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product,
    output logic              core_rst,
    output logic [SIZE-1:0]   core_x,
    output logic              core_y,
    input  logic              core_p
);

    localparam int unsigned PW = 2 * SIZE;
    localparam int unsigned CW = $clog2(PW + LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] mp_q, mp_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;
    logic [SIZE-1:0] core_x_q, core_x_d;
    logic            core_y_q, core_y_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            capture;

    // cnt counts from the first SHIFT cycle through DRAIN; product bit c-LAT is captured at cnt=c
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mp_d      = mp_q;
        acc_d     = acc_q;
        product_d = product_q;
        core_x_d  = core_x_q;
        core_y_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CLEAR;
                    core_x_d = mc;
                    mp_d     = mp;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            CLEAR: begin
                state_d  = SHIFT;
                core_y_d = mp_q[0];
                mp_d     = {mp_q[SIZE-1], mp_q[SIZE-1:1]};
            end
            SHIFT: begin
                capture = (cnt_q >= CW'(LAT));
                cnt_d   = cnt_q + CW'(1);
                // arithmetic shift keeps presenting the sign bit once the operand is exhausted
                if (cnt_q != CW'(PW - 1)) begin
                    core_y_d = mp_q[0];
                    mp_d     = {mp_q[SIZE-1], mp_q[SIZE-1:1]};
                end else begin
                    state_d = (LAT == 0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                capture = 1'b1;
                cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            acc_d = {core_p, acc_q[PW-1:1]};
            if (cnt_q == CW'(PW + LAT - 1)) begin
                product_d = acc_d;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mp_q      <= '0;
            acc_q     <= '0;
            product_q <= '0;
            core_x_q  <= '0;
            core_y_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mp_q      <= mp_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            core_x_q  <= core_x_d;
            core_y_q  <= core_y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign product  = product_q;
    assign core_x   = core_x_q;
    assign core_y   = core_y_q;
    assign core_rst = rst | (state_q == CLEAR);

endmodule

// File: tb/tb_spm_seq.sv
// Randomized bench for spm_seq with a behavioural serial-parallel multiplier core attached.
module tb_spm_seq;

    localparam int unsigned S        = 8;
    localparam int unsigned LAT      = 1;
    localparam int unsigned PW       = 2 * S;
    localparam int          DONE_CYC = int'(PW + LAT + 2);
    localparam int          LIMIT    = DONE_CYC + 20;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [S-1:0]  mc    = '0;
    logic [S-1:0]  mp    = '0;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;
    logic          core_rst;
    logic [S-1:0]  core_x;
    logic          core_y;
    logic          core_p = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spm_seq #(.SIZE(S), .LAT(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mc      (mc),
        .mp      (mp),
        .busy    (busy),
        .done    (done),
        .product (product),
        .core_rst(core_rst),
        .core_x  (core_x),
        .core_y  (core_y),
        .core_p  (core_p)
    );

    // Core model: product bit k depends only on multiplier bits 0..k, so emit bit k of
    // sext(x) * (multiplier bits received so far), registered once (LAT = 1).
    logic [PW-1:0] yacc = '0;
    int            idx  = 0;

    always @(posedge clk) begin : core_model
        logic [PW-1:0] ynew;
        logic [PW-1:0] prod;
        if (core_rst) begin
            yacc   <= '0;
            idx    <= 0;
            core_p <= 1'b0;
        end else if (idx < int'(PW)) begin
            ynew      = yacc;
            ynew[idx] = core_y;
            prod      = {{S{core_x[S-1]}}, core_x} * ynew;
            core_p   <= prod[idx];
            yacc     <= ynew;
            idx      <= idx + 1;
        end else begin
            core_p <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [S-1:0] a, input logic [S-1:0] b);
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        ea = PW'($signed(a));
        eb = PW'($signed(b));
        return PW'(ea * eb);
    endfunction

    // Caller sits #1 after an edge (cycle 0); returns #1 into the done cycle with start low.
    task automatic run_op(input logic [S-1:0] a, input logic [S-1:0] b, input bit noise);
        logic [PW-1:0] exp;
        int            done_cyc;
        exp      = ref_mul(a, b);
        done_cyc = 0;
        start    = 1'b1;
        mc       = a;
        mp       = b;
        for (int n = 1; n <= LIMIT && done_cyc == 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                chk("core_x_latched", 64'(core_x), 64'(a));
                chk("core_rst_clear", 64'(core_rst), 64'(1'b1));
            end
            if (n == 2)
                chk("core_rst_shift", 64'(core_rst), 64'(1'b0));
            if (done)
                done_cyc = n;
            else
                chk("busy_during_op", 64'(busy), 64'(1'b1));
            start = (noise && n < DONE_CYC) ? 1'b1 : 1'b0;
            mc    = S'($urandom);
            mp    = S'($urandom);
        end
        start = 1'b0;
        chk("done_latency", 64'(done_cyc), 64'(DONE_CYC));
        chk("product", 64'(product), 64'(exp));
        chk("busy_at_done", 64'(busy), 64'(1'b0));
    endtask

    function automatic logic [S-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return S'(8'h80);
            1:       return S'(8'h7F);
            2:       return '0;
            3:       return '1;
            default: return S'($urandom);
        endcase
    endfunction

    initial begin : stim
        int seen_done;
        logic [PW-1:0] held;

        // reset state
        rst = 1'b1;
        idle(3);
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_product", 64'(product), 64'(0));
        chk("rst_core_x", 64'(core_x), 64'(0));
        chk("rst_core_y", 64'(core_y), 64'(1'b0));
        chk("rst_core_rst", 64'(core_rst), 64'(1'b1));
        rst = 1'b0;
        idle(2);

        // directed products
        run_op(8'd3, 8'd5, 1'b0);
        chk("product_3x5", 64'(product), 64'(16'h000F));
        idle(1);
        chk("done_one_cycle", 64'(done), 64'(1'b0));
        chk("product_held", 64'(product), 64'(16'h000F));
        run_op(8'hFD, 8'd5, 1'b0);
        idle(1);
        run_op(8'd5, 8'hFD, 1'b0);
        idle(1);
        run_op(8'h80, 8'h80, 1'b0);
        chk("product_min_sq", 64'(product), 64'(16'h4000));
        idle(1);
        run_op(8'h7F, 8'h80, 1'b0);
        idle(1);
        run_op(8'h00, 8'hFF, 1'b0);
        idle(1);

        // start hammered during the operation, then a start in the done cycle
        run_op(8'h5A, 8'hC3, 1'b1);
        run_op(8'h11, 8'hEE, 1'b0);
        idle(2);

        // reset in cycle 10 aborts without a done pulse
        start = 1'b1;
        mc    = 8'h33;
        mp    = 8'h44;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n == 10) rst = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'(1'b0));
        chk("abort_product", 64'(product), 64'(0));
        chk("abort_core_y", 64'(core_y), 64'(1'b0));
        chk("abort_done", 64'(done), 64'(1'b0));
        rst = 1'b0;
        seen_done = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        chk("abort_no_done", 64'(seen_done), 64'(0));
        run_op(8'd7, 8'hF9, 1'b0);
        chk("product_after_abort", 64'(product), 64'(16'hFFCF));
        idle(1);

        // random operands, mixed spacing, occasional hammering and chaining
        for (int i = 0; i < 1000; i++) begin
            run_op(pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) != 0) begin
                held = product;
                idle($urandom_range(1, 3));
                chk("product_hold_idle", 64'(product), 64'(held));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
